// File: rtl/crc_codec_engine.sv
// Configurable CRC generator/checker: folds STEP message bits per clock using one of two
// polynomials, then emits a single-cycle registered result (codeword or check verdict).
module crc_codec_engine #(
  parameter int unsigned           MSG_W      = 60,
  parameter int unsigned           CRC_A_W    = 8,
  parameter logic [CRC_A_W-1:0]    CRC_A_POLY = 8'h31,
  parameter int unsigned           CRC_B_W    = 5,
  parameter logic [CRC_B_W-1:0]    CRC_B_POLY = 5'h0B,
  parameter int unsigned           STEP       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic             crc_sel,
  input  logic [MSG_W-1:0] message,
  output logic             out_valid,
  output logic [MSG_W-1:0] out,
  output logic             err
);

  localparam int unsigned R_W   = (CRC_A_W > CRC_B_W) ? CRC_A_W : CRC_B_W;
  localparam int unsigned CNT_W = $clog2(MSG_W + 1);
  localparam int unsigned N_A   = MSG_W - CRC_A_W;
  localparam int unsigned N_B   = MSG_W - CRC_B_W;

  localparam logic [R_W-1:0] POLY_A = R_W'(CRC_A_POLY);
  localparam logic [R_W-1:0] POLY_B = R_W'(CRC_B_POLY);
  localparam logic [R_W-1:0] MASK_A = R_W'((64'd1 << CRC_A_W) - 64'd1);
  localparam logic [R_W-1:0] MASK_B = R_W'((64'd1 << CRC_B_W) - 64'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [MSG_W-1:0]   sh_q, sh_d;
  logic [R_W-1:0]     r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               sel_q, sel_d;
  logic               out_valid_q, out_valid_d;
  logic [MSG_W-1:0]   out_q, out_d;
  logic               err_q, err_d;

  logic [R_W-1:0]     r_fold;
  logic [MSG_W-1:0]   sh_fold;
  logic [R_W-1:0]     poly;
  logic [R_W-1:0]     mask;
  logic [R_W-1:0]     rx_crc;
  logic               fb;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      msg_q       <= '0;
      sh_q        <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      sh_q        <= sh_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      err_q       <= err_d;
    end
  end

  // Next-state, CRC fold and result formation
  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    sh_d        = sh_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    sel_d       = sel_q;
    out_valid_d = 1'b0;
    out_d       = '0;
    err_d       = 1'b0;
    fb          = 1'b0;

    poly    = sel_q ? POLY_B : POLY_A;
    mask    = sel_q ? MASK_B : MASK_A;
    rx_crc  = R_W'(msg_q) & mask;
    r_fold  = r_q;
    sh_fold = sh_q;

    // Data bits are kept left-justified in sh so the next bit is always the MSB
    for (int unsigned k = 0; k < STEP; k++) begin
      if (CNT_W'(k) < cnt_q) begin
        fb      = sh_fold[MSG_W-1] ^ (sel_q ? r_fold[CRC_B_W-1] : r_fold[CRC_A_W-1]);
        r_fold  = ((r_fold << 1) ^ (fb ? poly : '0)) & mask;
        sh_fold = sh_fold << 1;
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          msg_d   = message;
          mode_d  = mode;
          sel_d   = crc_sel;
          r_d     = '0;
          cnt_d   = crc_sel ? CNT_W'(N_B) : CNT_W'(N_A);
          if (mode) begin
            sh_d = message;
          end else if (crc_sel) begin
            sh_d = message << CRC_B_W;
          end else begin
            sh_d = message << CRC_A_W;
          end
        end
      end
      CALC: begin
        r_d  = r_fold;
        sh_d = sh_fold;
        if (cnt_q <= CNT_W'(STEP)) begin
          cnt_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          if (!mode_q) begin
            out_d = (sel_q ? (msg_q << CRC_B_W) : (msg_q << CRC_A_W)) | MSG_W'(r_fold);
          end else if (r_fold != rx_crc) begin
            out_d = '1;
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(STEP);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_crc_codec_engine.sv
// Directed bench for crc_codec_engine, plus a sweep of four STEP variants against a bit-serial model.
module tb_crc_codec_engine;

  localparam int unsigned MW = 60;
  localparam logic [MW-1:0] ONES = '1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          mode = 1'b0;
  logic          crc_sel = 1'b0;
  logic [MW-1:0] message = '0;

  logic          rdy  [4];
  logic          ov   [4];
  logic [MW-1:0] outv [4];
  logic          errv [4];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  crc_codec_engine #(.STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .mode(mode),
    .crc_sel(crc_sel), .message(message), .out_valid(ov[0]), .out(outv[0]), .err(errv[0]));
  crc_codec_engine #(.STEP(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .mode(mode),
    .crc_sel(crc_sel), .message(message), .out_valid(ov[1]), .out(outv[1]), .err(errv[1]));
  crc_codec_engine #(.STEP(7)) u_s7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .mode(mode),
    .crc_sel(crc_sel), .message(message), .out_valid(ov[2]), .out(outv[2]), .err(errv[2]));
  crc_codec_engine #(.STEP(60)) u_s60 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]), .mode(mode),
    .crc_sel(crc_sel), .message(message), .out_valid(ov[3]), .out(outv[3]), .err(errv[3]));

  function automatic int step_of(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      2:       return 7;
      default: return 60;
    endcase
  endfunction

  // Bit-serial reference: returns {err, out}
  function automatic logic [MW:0] crc_ref(input logic [MW-1:0] m, input logic md, input logic sl);
    int w;
    int n;
    logic [7:0] poly;
    logic [7:0] mask;
    logic [7:0] r;
    logic d;
    logic fb;
    w    = sl ? 5 : 8;
    n    = MW - w;
    poly = sl ? 8'h0B : 8'h31;
    mask = sl ? 8'h1F : 8'hFF;
    r    = 8'h00;
    for (int i = n - 1; i >= 0; i--) begin
      d  = md ? m[w + i] : m[i];
      fb = d ^ r[w - 1];
      r  = ((r << 1) ^ (fb ? poly : 8'h00)) & mask;
    end
    if (!md) return {1'b0, (m << w) | MW'(r)};
    if (r == (m[7:0] & mask)) return {1'b0, {MW{1'b0}}};
    return {1'b1, ONES};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present one message for a single cycle; control inputs flip after acceptance
  task automatic send(input logic [MW-1:0] m, input logic md, input logic sl);
    @(negedge clk);
    chk("ready before send", 64'(rdy[1]), 64'd1);
    message  = m;
    mode     = md;
    crc_sel  = sl;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    mode     = ~md;
    crc_sel  = ~sl;
    message  = ~m;
  endtask

  task automatic expect_main(input string tag, input logic [MW-1:0] exp_out, input logic exp_err,
                             input int exp_lat);
    int lat;
    logic [MW-1:0] o;
    logic e;
    lat = 0;
    o   = '0;
    e   = 1'b0;
    for (int k = 1; k <= 80 && lat == 0; k++) begin
      @(negedge clk);
      if (ov[1]) begin
        lat = k;
        o   = outv[1];
        e   = errv[1];
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " out"}, 64'(o), 64'(exp_out));
    chk({tag, " err"}, 64'(e), 64'(exp_err));
    @(negedge clk);
    chk({tag, " pulse width"}, 64'(ov[1]), 64'd0);
    chk({tag, " out cleared"}, 64'(outv[1]), 64'd0);
    chk({tag, " ready after"}, 64'(rdy[1]), 64'd1);
  endtask

  task automatic sweep_vec(input logic [MW-1:0] m, input logic md, input logic sl);
    logic [MW:0]   ref_v;
    int            n;
    int            lat    [4];
    int            pulses [4];
    logic [MW-1:0] o      [4];
    logic          e      [4];
    ref_v = crc_ref(m, md, sl);
    n     = sl ? 55 : 52;
    for (int i = 0; i < 4; i++) begin
      lat[i] = 0; pulses[i] = 0; o[i] = '0; e[i] = 1'b0;
    end
    send(m, md, sl);
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (ov[i]) begin
          pulses[i]++;
          if (lat[i] == 0) begin
            lat[i] = k; o[i] = outv[i]; e[i] = errv[i];
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sweep step%0d latency", step_of(i)), 64'(lat[i]),
          64'((n + step_of(i) - 1) / step_of(i)));
      chk($sformatf("sweep step%0d out m=%0h", step_of(i), m), 64'(o[i]), 64'(ref_v[MW-1:0]));
      chk($sformatf("sweep step%0d err", step_of(i)), 64'(e[i]), 64'(ref_v[MW]));
      chk($sformatf("sweep step%0d pulses", step_of(i)), 64'(pulses[i]), 64'd1);
    end
  endtask

  initial begin
    int pulses;
    int seen;
    logic [MW-1:0] m;
    logic [MW:0] cw;
    logic md;
    logic sl;

    // Reset with in_valid held high
    message  = 60'h1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("in reset out_valid", 64'(ov[1]), 64'd0);
    chk("in reset out", 64'(outv[1]), 64'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    pulses   = 0;
    repeat (16) begin
      @(negedge clk);
      if (ov[1]) pulses++;
    end
    chk("post reset pulses", 64'(pulses), 64'd0);
    chk("reset in_ready", 64'(rdy[1]), 64'd1);
    chk("reset out", 64'(outv[1]), 64'd0);
    chk("reset err", 64'(errv[1]), 64'd0);

    // Generate mode
    send(60'h1, 1'b0, 1'b0);               expect_main("gen8 1", 60'h131, 1'b0, 13);
    send(60'h1, 1'b0, 1'b1);               expect_main("gen5 1", 60'h2B, 1'b0, 14);
    send(60'h0, 1'b0, 1'b0);               expect_main("gen8 0", 60'h0, 1'b0, 13);
    send(60'h0, 1'b0, 1'b1);               expect_main("gen5 0", 60'h0, 1'b0, 14);
    send(60'h2, 1'b0, 1'b0);               expect_main("gen8 2", 60'h262, 1'b0, 13);
    send(60'h2, 1'b0, 1'b1);               expect_main("gen5 2", 60'h56, 1'b0, 14);
    send(60'h80, 1'b0, 1'b0);              expect_main("gen8 80", 60'h807A, 1'b0, 13);
    send(60'hFF0_0000_0000_0001, 1'b0, 1'b0); expect_main("gen8 upper ignored", 60'h131, 1'b0, 13);

    // Check mode
    send(60'h131, 1'b1, 1'b0);             expect_main("chk8 good", 60'h0, 1'b0, 13);
    send(60'h1CE, 1'b1, 1'b0);             expect_main("chk8 bad", ONES, 1'b1, 13);
    send(60'h34, 1'b1, 1'b1);              expect_main("chk5 bad", ONES, 1'b1, 14);
    send(60'h2B, 1'b1, 1'b1);              expect_main("chk5 good", 60'h0, 1'b0, 14);

    // Back-pressure: second message held during CALC is taken only after in_ready
    send(60'h1, 1'b0, 1'b0);
    message  = 60'h3;
    mode     = 1'b0;
    crc_sel  = 1'b0;
    in_valid = 1'b1;
    expect_main("bp first", 60'h131, 1'b0, 13);
    @(negedge clk);
    in_valid = 1'b0;
    expect_main("bp second", 60'h353, 1'b0, 13);

    // Abort mid-CALC
    send(60'h80, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort calc out_valid", 64'(ov[1]), 64'd0);
    chk("abort calc out", 64'(outv[1]), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov[1]) pulses++;
    end
    chk("abort calc pulses", 64'(pulses), 64'd0);

    // Abort while the result is on the outputs
    send(60'h1CE, 1'b1, 1'b0);
    seen = 0;
    for (int k = 1; k <= 80 && seen == 0; k++) begin
      @(negedge clk);
      if (ov[1]) seen = 1;
    end
    chk("abort done pulse seen", 64'(seen), 64'd1);
    chk("abort done pre out", 64'(outv[1]), 64'(ONES));
    #1 rst_n = 1'b0;
    #1;
    chk("abort done out_valid", 64'(ov[1]), 64'd0);
    chk("abort done out", 64'(outv[1]), 64'd0);
    chk("abort done err", 64'(errv[1]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(60'h80, 1'b0, 1'b0);              expect_main("after abort", 60'h807A, 1'b0, 13);

    // Let every variant drain, then sweep all four STEP values together
    repeat (70) @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      m  = MW'({$urandom, $urandom});
      md = 1'($urandom_range(0, 1));
      sl = 1'($urandom_range(0, 1));
      if (md && (i % 2 == 0)) begin
        cw = crc_ref(m, 1'b0, sl);
        m  = cw[MW-1:0];
      end
      sweep_vec(m, md, sl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/crc_codec_engine.md
# crc_codec_engine

Parametrised single-clock CRC generator/checker that replaces the fixed CRC-8/CRC-5 datapath with a configurable engine: message width, both polynomials and bits processed per cycle are parameters, and an `in_ready` handshake adds input back-pressure. It sits between the input capture stage and the output stage of the CRC subsystem. It accepts one message, computes the CRC over several cycles, then emits one single-cycle result.

## Interface
- `MSG_W`, default 60: message/codeword width.
- `CRC_A_W`, default 8: width of polynomial A, selected when `crc_sel`=0.
- `CRC_A_POLY`, default 8'h31: polynomial A, low bits with the leading 1 implicit (x^8+x^5+x^4+1).
- `CRC_B_W`, default 5: width of polynomial B, selected when `crc_sel`=1.
- `CRC_B_POLY`, default 5'h0B: polynomial B (x^5+x^3+x+1).
- `STEP`, default 4: message bits folded per clock. Legal range is 1 to `MSG_W`.
- `clk`, input, 1: the single clock. All logic is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: the message is presented this cycle.
- `in_ready`, output, 1: the engine can accept a message.
- `mode`, input, 1: 0 = generate, 1 = check.
- `crc_sel`, input, 1: 0 = polynomial A, 1 = polynomial B.
- `message`, input, `MSG_W`: message input.
- `out_valid`, output, 1: result pulse.
- `out`, output, `MSG_W`: result.
- `err`, output, 1: check-mode mismatch flag.

## Operation
- W is the active CRC width (`CRC_A_W` or `CRC_B_W`). N = `MSG_W` − W is the number of data bits.
- Data bits are `message[N-1:0]`. `message[MSG_W-1:N]` is ignored in generate mode.
- In check mode, `message[W-1:0]` is the received CRC and the data bits are `message[MSG_W-1:W]`.
- CRC algorithm (non-augmented, MSB first):
  - The register `r` of width W starts at 0.
  - For each data bit d: fb = d ^ r[W-1]; r = (r<<1) ^ (fb ? POLY : 0).
  - After N bits, r is the CRC.
- Generate mode result: `out` = {data, r}, `err` = 0.
- Check mode result:
  - If r equals the received CRC: `out` = 0 and `err` = 0.
  - Otherwise: `out` = all ones and `err` = 1.
- FSM states:
  - IDLE: `in_ready`=1. When `in_valid`=1, capture `message`, `mode` and `crc_sel`, clear r, load the remaining-bit count with N, and go to CALC.
  - CALC: fold min(`STEP`, remaining) bits in one cycle. On the edge that folds the last chunk, register `out`/`err` and go to DONE. A partial final chunk is legal; for example, CRC-5 with STEP=4 gives 55 bits = 13×4 + 3.
  - DONE: `out_valid`=1 for exactly one cycle, then go to IDLE.
- `in_ready` = (state==IDLE). `in_valid` is ignored in CALC and DONE. There is no queuing, so the source holds the message until it sees `in_ready`.
- `crc_sel` and `mode` are sampled only at acceptance. Changing them mid-computation has no effect.
- Bit-counter width is clog2(`MSG_W`+1).

## Timing
- Reset (asynchronous assert, synchronous effect on release):
  - state = IDLE, r = 0, counter = 0.
  - `out_valid` = 0, `out` = 0, `err` = 0.
  - `in_ready` = 1 once `rst_n` is high. Inputs are not captured while `rst_n` = 0.
- Reset asserted mid-CALC or in DONE aborts immediately: no `out_valid` pulse, and outputs clear without waiting for a clock.
- Latency: C = ceil(N/`STEP`). With acceptance at edge 0, `out_valid` rises after edge C and falls after edge C+1.
  - Defaults: CRC-8 gives C=13, CRC-5 gives C=14.
- `out` and `err` are registered. Both are 0 whenever `out_valid`=0.
- Throughput: one message per C+2 cycles. `in_ready` rises in the cycle `out_valid` falls.
- STEP ≥ N: C=1 and the whole message is folded in one cycle.

## Test plan
- Reset idle check: after reset, `in_ready`=1, `out_valid`=0, `out`=0. Holding `in_valid`=1 with `rst_n`=0 must produce no pulse.
- Generate, CRC-8: `message`=60'h1, `mode`=0, `crc_sel`=0 -> `out`=60'h131, `err`=0, `out_valid` is one cycle wide, 13 cycles after acceptance.
- Generate, CRC-5: `message`=60'h1, `mode`=0, `crc_sel`=1 -> `out`=60'h2B, 14 cycles after acceptance.
- Generate, zero data: `message`=0, `mode`=0 -> `out`=0 for both polynomials.
- Check mode:
  - `message`=60'h131, `crc_sel`=0 -> `out`=0, `err`=0.
  - `message`=60'h1CE, `crc_sel`=0 -> `out`=all ones, `err`=1.
  - `message`=60'h34, `crc_sel`=1 -> `out`=all ones, `err`=1.
- Back-pressure and abort:
  - Present a second message during CALC: it is ignored. Only the first result appears, and the second is accepted only once `in_ready` is 1.
  - Drop `rst_n` mid-CALC: no pulse follows, all outputs are 0, and the next message produces the correct CRC.
- Randomised sweep against a bit-serial reference model, with `STEP` ∈ {1, 4, 7, 60}.
